restoring_divider_16bit: RTL and testbench

Sequential 32-by-16 unsigned restoring divider producing a 16-bit quotient and 16-bit remainder, one quotient bit per clock. It is the inverse companion of the team's 16x16 array multiplier: it accepts a 32-bit product-width dividend and recovers the 16-bit factor. It sits beside the multiplier in the arithmetic lab datapath behind a start/busy/done handshake.

---
 rtl/restoring_divider_16bit.sv | 161 ++++++++++++++++
 tb/tb_restoring_divider_16bit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_16bit.sv
// rtl/restoring_divider_16bit.sv - 32/16 unsigned restoring divider, one quotient bit per clock
// Optional macro DIVIDER_EXCEPTION_CHECK_EN flags divide-by-zero/overflow up front.
module restoring_divider_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [16:0] r;
    logic [15:0] q;
    logic [15:0] d;
    logic [3:0]  cnt;

    logic [16:0] r_sh;
    logic [17:0] diff;
    logic        borrow;
    logic [16:0] r_next;
    logic [15:0] q_next;
    logic        accept;
    logic        finish;
    logic        blocked;

`ifdef DIVIDER_EXCEPTION_CHECK_EN
    logic exc_pend;
    logic exc_hit;
    logic exc_fire;

    assign exc_hit  = (divisor == 16'h0000) || (dividend[31:16] >= divisor);
    assign exc_fire = (state == IDLE) && exc_pend;
    assign blocked  = exc_pend;
`else
    assign blocked  = 1'b0;
    assign error    = 1'b0;
`endif

    // A set r[16] means the true shifted value exceeds any divisor, so never borrow.
    always_comb begin
        r_sh   = {r[15:0], q[15]};
        diff   = {1'b0, r_sh} - {2'b00, d};
        borrow = diff[17] & ~r[16];
        if (borrow) begin
            r_next = r_sh;
            q_next = {q[14:0], 1'b0};
        end else begin
            r_next = diff[16:0];
            q_next = {q[14:0], 1'b1};
        end
    end

    // DONE falls through to the IDLE accept so back-to-back runs complete every 17 cycles.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !blocked) begin
                    accept = 1'b1;
                end
`ifdef DIVIDER_EXCEPTION_CHECK_EN
                if (exc_pend) begin
                    state_next = DONE;
                end
`endif
            end
            RUN: begin
                if (cnt == 4'd15) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                if (start) begin
                    accept = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (accept) begin
`ifdef DIVIDER_EXCEPTION_CHECK_EN
            state_next = exc_hit ? IDLE : RUN;
`else
            state_next = RUN;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            r         <= 17'd0;
            q         <= 16'd0;
            d         <= 16'd0;
            cnt       <= 4'd0;
            quotient  <= 16'd0;
            remainder <= 16'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                r   <= {1'b0, dividend[31:16]};
                q   <= dividend[15:0];
                d   <= divisor;
                cnt <= 4'd0;
            end else if (state == RUN) begin
                r   <= r_next;
                q   <= q_next;
                cnt <= cnt + 4'd1;
            end
            if (finish) begin
                quotient  <= q_next;
                remainder <= r_next[15:0];
            end
`ifdef DIVIDER_EXCEPTION_CHECK_EN
            if (exc_fire) begin
                quotient  <= 16'hFFFF;
                remainder <= 16'h0000;
            end
`endif
        end
    end

`ifdef DIVIDER_EXCEPTION_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_pend <= 1'b0;
            error    <= 1'b0;
        end else begin
            if (accept) begin
                exc_pend <= exc_hit;
            end else if (exc_fire) begin
                exc_pend <= 1'b0;
            end
            if (finish) begin
                error <= 1'b0;
            end else if (exc_fire) begin
                error <= 1'b1;
            end
        end
    end
`endif

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_restoring_divider_16bit.sv
// tb/tb_restoring_divider_16bit.sv - randomized self-checking bench for restoring_divider_16bit
module tb_restoring_divider_16bit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        error;

    int checks = 0;
    int errors = 0;

    restoring_divider_16bit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation, scramble the operand inputs after acceptance and time the result.
    task automatic run_op(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                          input int exp_lat, input logic [15:0] exp_q,
                          input logic [15:0] exp_r, input logic exp_e);
        int lat;
        int busy_cnt;
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        lat      = 0;
        busy_cnt = 0;
        @(negedge clk);
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'((exp_lat == 16) ? 16 : 0));
        check({tag, " busy at done"}, 64'(busy), 64'd0);
        check({tag, " quotient"}, 64'(quotient), 64'(exp_q));
        check({tag, " remainder"}, 64'(remainder), 64'(exp_r));
        check({tag, " error"}, 64'(error), 64'(exp_e));
        @(negedge clk);
        check({tag, " done pulse width"}, 64'(done), 64'd0);
    endtask

    task automatic run_div(input string tag, input logic [31:0] dvd, input logic [15:0] dvs);
        logic [31:0] rq;
        logic [31:0] rr;
        rq = dvd / {16'd0, dvs};
        rr = dvd % {16'd0, dvs};
        run_op(tag, dvd, dvs, 16, rq[15:0], rr[15:0], 1'b0);
    endtask

    initial begin
        logic [31:0] cur_dvd;
        logic [15:0] cur_dvs;
        logic [31:0] nxt_dvd;
        logic [15:0] nxt_dvs;
        logic [31:0] rq;
        logic [31:0] rr;
        logic [15:0] hi;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs", {29'd0, busy, done, error, quotient, remainder}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle after reset", {29'd0, busy, done, error, quotient, remainder}, 64'd0);

        run_div("1000/7", 32'h0000_03E8, 16'h0007);
        run_div("max/max", 32'hFFFE_0001, 16'hFFFF);
        run_div("65536/3", 32'h0001_0000, 16'h0003);

`ifdef DIVIDER_EXCEPTION_CHECK_EN
        run_op("div0", 32'h0000_1234, 16'h0000, 1, 16'hFFFF, 16'h0000, 1'b1);
        run_op("overflow", 32'h0005_0000, 16'h0005, 1, 16'hFFFF, 16'h0000, 1'b1);
        run_div("after exception", 32'h0000_03E8, 16'h0007);
`else
        run_op("div0", 32'h0000_1234, 16'h0000, 16, 16'hFFFF, 16'h1234, 1'b0);
`endif

        // A start pulse during RUN must be dropped.
        rq = 32'd100 / 32'd3;
        rr = 32'd100 % 32'd3;
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 16'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        dividend = 32'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("ignored start busy k+15", 64'(busy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("ignored start done k+16", 64'(done), 64'd1);
        check("ignored start quotient", 64'(quotient), 64'(rq[15:0]));
        check("ignored start remainder", 64'(remainder), 64'(rr[15:0]));
        @(negedge clk);
        check("ignored start no relaunch", {62'd0, busy, done}, 64'd0);

        // Reset mid-RUN clears everything immediately.
        @(negedge clk);
        dividend = 32'h0000_03E8;
        divisor  = 16'h0007;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid-run reset outputs", {29'd0, busy, done, error, quotient, remainder}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post reset idle", {62'd0, busy, done}, 64'd0);
        run_div("1000/7 after reset", 32'h0000_03E8, 16'h0007);

        // Back-to-back sweep with start held high: one result every 17 cycles.
        cur_dvs = 16'($urandom_range(1, 65535));
        hi      = 16'($urandom_range(0, int'(cur_dvs) - 1));
        cur_dvd = {hi, 16'($urandom)};
        @(negedge clk);
        dividend = cur_dvd;
        divisor  = cur_dvs;
        start    = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            @(negedge clk);
            if ((i % 4) == 0) nxt_dvs = 16'($urandom_range(1, 255));
            else nxt_dvs = 16'($urandom_range(1, 65535));
            hi      = 16'($urandom_range(0, int'(nxt_dvs) - 1));
            nxt_dvd = {hi, 16'($urandom)};
            dividend = nxt_dvd;
            divisor  = nxt_dvs;
            rq = cur_dvd / {16'd0, cur_dvs};
            rr = cur_dvd % {16'd0, cur_dvs};
            repeat (16) @(posedge clk);
            @(negedge clk);
            check("sweep done cadence", 64'(done), 64'd1);
            check("sweep quotient", 64'(quotient), 64'(rq[15:0]));
            check("sweep remainder", 64'(remainder), 64'(rr[15:0]));
            cur_dvd = nxt_dvd;
            cur_dvs = nxt_dvs;
            if (i == 999) start = 1'b0;
        end
        @(negedge clk);
        check("sweep stops", {62'd0, busy, done}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
